program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal values are even and at least 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-004 rx  input  1  serial line, idle high, 8N1 framing, LSB first; asynchronous to clk.
REQ-005 load_req  input  1  one-cycle pulse requesting a program (re)load.
REQ-006 pm_wr_en  output  1  program-memory write strobe, one cycle per byte.
REQ-007 pm_wr_addr  output  8  program-memory write address.
REQ-008 pm_wr_data  output  8  program-memory write data.
REQ-009 cpu_hold  output  1  high holds the microprocessor in reset while loading.
REQ-010 done  output  1  high once a load completes, until the next load_req.
REQ-011 error  output  1  high after a framing error, until the next load_req.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-013 Receiver SHALL detect a start bit on a synchronized high-to-low transition while idle.
REQ-014 Receiver SHALL re-sample at CLKS_PER_BIT/2 cycles after the edge and return to idle with no output if rx is high (glitch reject).
REQ-015 Receiver SHALL then sample 8 data bits, LSB first, and one stop bit, each exactly CLKS_PER_BIT cycles apart.
REQ-016 Stop bit = 1 SHALL produce a one-cycle byte_valid with the byte; stop bit = 0 SHALL produce a one-cycle frame_err and no byte.
REQ-017 Loader FSM states: IDLE, LEN, DATA, DONE, ERR.
REQ-018 IDLE: cpu_hold=0, done=0, error=0; load_req -> LEN.
REQ-019 LEN: cpu_hold=1; first byte_valid sets remaining count = byte, with 0 meaning 256 (9-bit count), sets address = 0, and moves to DATA.
REQ-020 DATA: each byte_valid SHALL produce pm_wr_en=1 on the following cycle, with pm_wr_addr = current address and pm_wr_data = byte; address then increments and count decrements.
REQ-021 The write of the final byte (count reaching 0) SHALL move the FSM to DONE; address 255 is the last possible write, and the address never wraps within one load.
REQ-022 DONE: cpu_hold=0 and done=1, starting the cycle after the final pm_wr_en; load_req -> LEN.
REQ-023 frame_err in LEN or DATA -> ERR: error=1, cpu_hold=1, no further writes; load_req -> LEN.
REQ-024 load_req SHALL be ignored in LEN and DATA; byte_valid and frame_err SHALL be ignored in IDLE, DONE and ERR.
REQ-025 On load_req, done and error SHALL clear on entry to LEN.
REQ-026 pm_wr_en SHALL be 0 in every cycle except the single cycle following an accepted DATA byte.

Reset
REQ-027 reset low SHALL force, asynchronously: FSM=IDLE, receiver idle, synchronizer flops=1, pm_wr_en=0, pm_wr_addr=0, pm_wr_data=0, cpu_hold=0, done=0, error=0, count=0.
REQ-028 Reset during LEN or DATA SHALL abandon the load with no further writes; a partially received byte SHALL be discarded.

Structure
REQ-029 Shared package loader_pkg SHALL hold the FSM state enum and the default CLKS_PER_BIT constant.
REQ-030 The serial receiver (REQ-012 to REQ-016) SHALL be a sub-module uart_rx_byte with outputs byte_valid, byte_data[7:0] and frame_err.
REQ-031 pm_wr_* SHALL be driven from registers; no combinational path from rx to any output.

Verification
REQ-032 load_req, then bytes 0x03, 0xA1, 0xB2, 0xC3 -> three pm_wr_en pulses: addr 0/1/2 with data A1/B2/C3; cpu_hold falls and done rises the cycle after the third write.
REQ-033 Length byte 0x00 followed by 256 bytes -> 256 writes at addresses 0..255, then DONE; a 257th byte produces no write.
REQ-034 Stop bit forced to 0 on the second data byte -> one write at addr 0, then ERR with error=1 and cpu_hold=1; a new load_req plus a valid stream completes normally.
REQ-035 rx low pulse of CLKS_PER_BIT/2-1 cycles while idle -> no byte_valid and no frame_err.
REQ-036 Reset asserted mid-DATA -> all outputs 0 immediately; load_req after release restarts at addr 0.
REQ-037 load_req pulsed during DATA -> no effect; count and address continue unchanged.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and defaults for the serial program loader.
// Holds loader/receiver state encodings and the bit-period default.
package loader_pkg;

  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    DONE,
    ERR
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 serial byte receiver with 2-flop input synchronizer.
// Mid-bit sampling; emits byte_valid or frame_err for one cycle.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  rx_state_t     state, state_n;
  logic          sync1, sync2, prev;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          bv_n, fe_n;

  assign byte_data = shreg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      prev       <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync1      <= rx;
      sync2      <= sync1;
      prev       <= sync2;
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shreg      <= shreg_n;
      byte_valid <= bv_n;
      frame_err  <= fe_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    shreg_n = shreg;
    bv_n    = 1'b0;
    fe_n    = 1'b0;
    unique case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (prev && !sync2) state_n = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_M1) begin
          cnt_n = '0;
          idx_n = '0;
          // line back high at mid-start: treat as a glitch
          state_n = sync2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          shreg_n = {sync2, shreg[7:1]};
          idx_n   = idx + 1'b1;
          if (idx == 3'd7) state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          state_n = RX_IDLE;
          bv_n    = sync2;
          fe_n    = !sync2;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/program_loader.sv
// Serial program loader: length byte then payload into program memory.
// Holds the CPU in reset while a load is in progress.
module program_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       load_req,
  output logic       pm_wr_en,
  output logic [7:0] pm_wr_addr,
  output logic [7:0] pm_wr_data,
  output logic       cpu_hold,
  output logic       done,
  output logic       error
);

  ld_state_t  state, state_n;
  logic [8:0] count, count_n;
  logic [7:0] addr, addr_n;
  logic       we_n;
  logic [7:0] wa_n, wd_n;
  logic       byte_valid, frame_err;
  logic [7:0] byte_data;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      addr       <= '0;
      pm_wr_en   <= 1'b0;
      pm_wr_addr <= '0;
      pm_wr_data <= '0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      addr       <= addr_n;
      pm_wr_en   <= we_n;
      pm_wr_addr <= wa_n;
      pm_wr_data <= wd_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    addr_n  = addr;
    we_n    = 1'b0;
    wa_n    = pm_wr_addr;
    wd_n    = pm_wr_data;
    unique case (state)
      LEN: begin
        if (frame_err) begin
          state_n = ERR;
        end else if (byte_valid) begin
          count_n = (byte_data == 8'd0) ? 9'd256 : {1'b0, byte_data};
          addr_n  = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        // count hits 0 on the last write; leave one cycle later
        if (frame_err) begin
          state_n = ERR;
        end else if (count == 9'd0) begin
          state_n = DONE;
        end else if (byte_valid) begin
          we_n    = 1'b1;
          wa_n    = addr;
          wd_n    = byte_data;
          addr_n  = addr + 1'b1;
          count_n = count - 1'b1;
        end
      end
      default: begin
        if (load_req) state_n = LEN;
      end
    endcase
  end

  always_comb begin
    cpu_hold = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state)
      LEN, DATA: cpu_hold = 1'b1;
      DONE:      done = 1'b1;
      ERR: begin
        error    = 1'b1;
        cpu_hold = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: serial frames in, write log checked.
// Expected addresses/data are hand-computed from the driven streams.
module tb_program_loader;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       load_req = 1'b0;
  logic       pm_wr_en;
  logic [7:0] pm_wr_addr;
  logic [7:0] pm_wr_data;
  logic       cpu_hold;
  logic       done;
  logic       error;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int done_cyc = -1;
  logic done_q = 1'b0;
  int bv_cnt = 0;
  int fe_cnt = 0;
  int bv0, fe0;

  logic [7:0] wa_q[$];
  logic [7:0] wd_q[$];
  int         wc_q[$];
  logic       wh_q[$];

  program_loader #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .load_req  (load_req),
    .pm_wr_en  (pm_wr_en),
    .pm_wr_addr(pm_wr_addr),
    .pm_wr_data(pm_wr_data),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (pm_wr_en) begin
      wa_q.push_back(pm_wr_addr);
      wd_q.push_back(pm_wr_data);
      wc_q.push_back(cyc);
      wh_q.push_back(cpu_hold);
    end
    if (done && !done_q) done_cyc = cyc;
    done_q = done;
    if (dut.u_rx.byte_valid) bv_cnt = bv_cnt + 1;
    if (dut.u_rx.frame_err) fe_cnt = fe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp)
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    wh_q.delete();
    done_cyc = -1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    @(posedge clk);
    #1 load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  initial begin
    // reset state
    wait_cyc(3);
    chk("rst_wr_en", pm_wr_en, 0);
    chk("rst_addr", pm_wr_addr, 0);
    chk("rst_data", pm_wr_data, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    reset = 1'b1;
    wait_cyc(4);

    // basic three-byte load
    clear_log();
    pulse_load();
    chk("len_hold", cpu_hold, 1);
    send_byte(8'h03, 1'b1);
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    send_byte(8'hC3, 1'b1);
    wait_cyc(4);
    chk("b3_count", wa_q.size(), 3);
    chk("b3_a0", wa_q[0], 8'h00);
    chk("b3_d0", wd_q[0], 8'hA1);
    chk("b3_a1", wa_q[1], 8'h01);
    chk("b3_d1", wd_q[1], 8'hB2);
    chk("b3_a2", wa_q[2], 8'h02);
    chk("b3_d2", wd_q[2], 8'hC3);
    chk("b3_hold_at_wr", wh_q[2], 1);
    chk("b3_done_timing", done_cyc, wc_q[2] + 1);
    chk("b3_done", done, 1);
    chk("b3_hold", cpu_hold, 0);
    chk("b3_error", error, 0);

    // short low glitch while idle
    bv0 = bv_cnt;
    fe0 = fe_cnt;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (CPB / 2 - 1) @(posedge clk);
    #1 rx = 1'b1;
    wait_cyc(3 * CPB);
    chk("glitch_bv", bv_cnt, bv0);
    chk("glitch_fe", fe_cnt, fe0);
    chk("glitch_done", done, 1);

    // framing error on second data byte, then recovery
    clear_log();
    pulse_load();
    chk("err_done_clr", done, 0);
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    wait_cyc(4);
    chk("err_count", wa_q.size(), 1);
    chk("err_a0", wa_q[0], 8'h00);
    chk("err_d0", wd_q[0], 8'h11);
    chk("err_flag", error, 1);
    chk("err_hold", cpu_hold, 1);
    chk("err_done", done, 0);
    send_byte(8'h33, 1'b1);
    wait_cyc(4);
    chk("err_no_more_wr", wa_q.size(), 1);
    clear_log();
    pulse_load();
    chk("err_clr", error, 0);
    chk("err_reload_hold", cpu_hold, 1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h5A, 1'b1);
    wait_cyc(4);
    chk("rec_count", wa_q.size(), 1);
    chk("rec_a0", wa_q[0], 8'h00);
    chk("rec_d0", wd_q[0], 8'h5A);
    chk("rec_done", done, 1);

    // reset mid-DATA with a partial byte on the line
    clear_log();
    pulse_load();
    send_byte(8'h05, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h20, 1'b1);
    chk("mid_count", wa_q.size(), 2);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_wr_en", pm_wr_en, 0);
    chk("mid_rst_addr", pm_wr_addr, 0);
    chk("mid_rst_data", pm_wr_data, 0);
    chk("mid_rst_hold", cpu_hold, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_error", error, 0);
    rx = 1'b1;
    wait_cyc(5);
    reset = 1'b1;
    wait_cyc(3 * CPB);
    chk("post_rst_no_wr", wa_q.size(), 2);
    clear_log();
    pulse_load();
    send_byte(8'h01, 1'b1);
    send_byte(8'h77, 1'b1);
    wait_cyc(4);
    chk("post_rst_count", wa_q.size(), 1);
    chk("post_rst_a0", wa_q[0], 8'h00);
    chk("post_rst_d0", wd_q[0], 8'h77);
    chk("post_rst_done", done, 1);

    // load_req during DATA is ignored
    clear_log();
    pulse_load();
    send_byte(8'h03, 1'b1);
    send_byte(8'h01, 1'b1);
    pulse_load();
    chk("ign_hold", cpu_hold, 1);
    chk("ign_done", done, 0);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    wait_cyc(4);
    chk("ign_count", wa_q.size(), 3);
    chk("ign_a1", wa_q[1], 8'h01);
    chk("ign_d1", wd_q[1], 8'h02);
    chk("ign_a2", wa_q[2], 8'h02);
    chk("ign_d2", wd_q[2], 8'h03);
    chk("ign_done_end", done, 1);

    // full 256-byte load from a zero length byte
    clear_log();
    pulse_load();
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'(i * 7 + 3);
      send_byte(v, 1'b1);
    end
    wait_cyc(4);
    chk("full_count", wa_q.size(), 256);
    for (int i = 0; i < wa_q.size(); i++) begin
      logic [7:0] v;
      v = 8'(i * 7 + 3);
      chk($sformatf("full_a%0d", i), wa_q[i], i);
      chk($sformatf("full_d%0d", i), wd_q[i], v);
    end
    chk("full_done", done, 1);
    chk("full_hold", cpu_hold, 0);
    send_byte(8'hEE, 1'b1);
    wait_cyc(4);
    chk("full_257_no_wr", wa_q.size(), 256);
    chk("full_257_done", done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
